gf_horner_eval: RTL
===================

Name: gf_horner_eval

Overview:
- Sequencer that evaluates a polynomial p(x) = c_t·x^t + … + c_0 over GF(2^16) at a point alpha using Horner's rule.
- Sits directly upstream of the team's GF(2^16) field multiplier (field polynomial x^16+x^5+x^3+x^2+1). It drives the multiplier operand inputs, consumes its product, and adds (XOR) the streamed coefficients.
- Used for syndrome and error-locator evaluation in the Niederreiter decoder datapath.

Parameters:
- M, 16, field width in bits.
- DEG_W, 8, width of the degree input; maximum degree is 2^DEG_W-1.
- MUL_LAT, 1, multiplier latency: cycles from stable mul_a/mul_b to valid mul_c; must be ≥1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- alpha  in  M  evaluation point; latched on accepted start.
- degree  in  DEG_W  t = number of coefficients minus 1; latched on accepted start.
- coef_valid  in  1  coefficient stream valid.
- coef_in  in  M  coefficient, highest degree first (c_t … c_0).
- coef_ready  out  1  block accepts coef_in this cycle.
- mul_a  out  M  multiplier operand A (accumulator).
- mul_b  out  M  multiplier operand B (latched alpha).
- mul_c  in  M  multiplier product.
- result  out  M  p(alpha); valid from the done cycle until the next accepted start.
- done  out  1  one-cycle pulse when result is valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; acc, result, mul_a, mul_b, alpha_r, cnt, wait counter all 0; done=0, coef_ready=0, busy=0. Reset during any state aborts the evaluation immediately. No partial result is kept.
- A handshake occurs when coef_valid && coef_ready on a rising edge.
- IDLE: on start, latch alpha_r←alpha, cnt←degree, go to LOAD. Start is ignored in all other states.
- LOAD: coef_ready=1. On handshake acc←coef_in. If cnt==0, go to DONE; otherwise go to MUL with wait counter←0.
- MUL: coef_ready=0; mul_a=acc, mul_b=alpha_r, held stable. The state lasts exactly MUL_LAT cycles. On the last cycle prod←mul_c, then go to ADD.
- ADD: coef_ready=1. On handshake acc←prod XOR coef_in and cnt←cnt-1. If the old cnt==1, go to DONE; otherwise go to MUL. Without a handshake, hold the state and all registers (backpressure of any length).
- DONE: result←acc, done=1 for exactly one cycle, then IDLE. busy=1 during DONE.
- Addition is a bitwise XOR with no carries; all values are M bits and there is no overflow.
- mul_a/mul_b hold their last values outside MUL; the multiplier is free-running and its output is sampled only at the end of MUL.
- Latency with no stalls: accepted start → done = t·(MUL_LAT+1)+2 cycles.
  - 1 cycle for LOAD.
  - t·(MUL_LAT+1) cycles for the MUL/ADD iterations.
  - 1 cycle to enter DONE.
- degree=0: the single coefficient is returned unchanged and no multiply is issued.
- Coefficients beyond t+1 are not accepted (coef_ready=0 outside LOAD/ADD). An upstream source holding coef_valid high has no effect in IDLE, MUL or DONE.
- The result register holds its value through IDLE until the next DONE overwrites it.

Test Plan:
(Bench wires the team's GF(2^16) multiplier to mul_a/mul_b/mul_c with MUL_LAT=1.)
- alpha=0x0002, t=1, coefs 0x8000, 0x0000 → result 0x002D (x^16 reduction), done 4 cycles after start.
- alpha=0x0001, t=2, coefs 0x1234, 0x4321, 0x2222 → result 0x7337; mul_b=0x0001 in every MUL cycle.
- t=0, coef 0x1234, alpha=0xFFFF → result 0x1234, done 2 cycles after start, mul_a never updated.
- alpha=0x0000, t=2, coefs 0xABCD, 0x1111, 0x0042 → result 0x0042. Drop coef_valid for 3 cycles in each ADD → state and acc held, done delayed by exactly 6 cycles, result unchanged.
- Start pulsed again while busy, and coef_valid held high during MUL → ignored: exactly t+1 handshakes, one done pulse.
- rst asserted in the second MUL of a t=3 run → next cycle: IDLE, busy=0, result=0x0000, coef_ready=0. A new run with alpha=0x0002, t=1, coefs 0x0001, 0x0000 then completes with result 0x0002.

Source files
------------

// File: rtl/gf_horner_eval.sv
// gf_horner_eval: evaluates p(x) = c_t*x^t + ... + c_0 over GF(2^M) at alpha
// with Horner's rule. acc = c_t; then repeatedly acc = acc*alpha ^ c_k, with the
// multiply done by an external field multiplier (mul_a * mul_b -> mul_c).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin an evaluation (sampled only when idle)
//   alpha, degree   evaluation point and t, latched on accepted start
//   coef_valid/in   coefficient stream, highest degree first
//   coef_ready      coefficient accepted this cycle when coef_valid is high
//   mul_a, mul_b    multiplier operands (accumulator, latched alpha)
//   mul_c           multiplier product, sampled on the last MUL cycle
//   result, done    p(alpha) and its one-cycle valid pulse
//   busy            evaluation in progress
module gf_horner_eval #(
  parameter int unsigned M       = 16,
  parameter int unsigned DEG_W   = 8,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [M-1:0]     alpha,
  input  logic [DEG_W-1:0] degree,
  input  logic             coef_valid,
  input  logic [M-1:0]     coef_in,
  output logic             coef_ready,
  output logic [M-1:0]     mul_a,
  output logic [M-1:0]     mul_b,
  input  logic [M-1:0]     mul_c,
  output logic [M-1:0]     result,
  output logic             done,
  output logic             busy
);

  localparam int unsigned WAIT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_ADD  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [M-1:0]      acc_q, acc_d;
  logic [M-1:0]      prod_q, prod_d;
  logic [M-1:0]      alpha_q, alpha_d;
  logic [DEG_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [M-1:0]      result_q, result_d;
  logic [M-1:0]      mul_a_q, mul_a_d;
  logic [M-1:0]      mul_b_q, mul_b_d;
  logic              coef_ready_q, coef_ready_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              hs_c;

  // coef_ready is registered, so a handshake is decided on the current flop value
  assign hs_c = coef_valid & coef_ready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    prod_d       = prod_q;
    alpha_d      = alpha_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    result_d     = result_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          alpha_d = alpha;
          cnt_d   = degree;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (hs_c) begin
          acc_d  = coef_in;
          wait_d = '0;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        // Operands are held for MUL_LAT cycles; product taken on the last one
        if (wait_q == WAIT_LAST) begin
          prod_d  = mul_c;
          state_d = S_ADD;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_ADD: begin
        if (hs_c) begin
          acc_d  = prod_q ^ coef_in;
          cnt_d  = cnt_q - DEG_W'(1);
          wait_d = '0;
          if (cnt_q == DEG_W'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MUL;
          end
        end
      end

      S_DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Operands are loaded only when entering MUL, so they stay stable inside it
    // and keep their last values everywhere else.
    if ((state_d == S_MUL) && (state_q != S_MUL)) begin
      mul_a_d = acc_d;
      mul_b_d = alpha_d;
    end

    coef_ready_d = (state_d == S_LOAD) || (state_d == S_ADD);
    busy_d       = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      prod_q       <= '0;
      alpha_q      <= '0;
      cnt_q        <= '0;
      wait_q       <= '0;
      result_q     <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      coef_ready_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      prod_q       <= prod_d;
      alpha_q      <= alpha_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      result_q     <= result_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      coef_ready_q <= coef_ready_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign coef_ready = coef_ready_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign result     = result_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule
